// File: rtl/vec_cpu.sv
// Vector co-processor: 512x32 RAM, four 16-word vector registers, burst moves and lane-wise add/mult.
// Define CPU_RAM_CLEAR_EN to make rst_n also clear every RAM word asynchronously.
module vec_cpu #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int VEC_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 op,
  input  logic [ADDR_W-1:0]          ram_addr,
  input  logic [$clog2(VEC_LEN)-1:0] ram_cnt,
  input  logic [1:0]                 reg_sel,
  input  logic [DATA_W-1:0]          ram_input  [0:VEC_LEN-1],
  output logic [DATA_W-1:0]          ram_output [0:VEC_LEN-1]
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int AW1   = ADDR_W + 1;
  localparam int CW    = $clog2(VEC_LEN);

  localparam logic [2:0] OP_RAM_TO_REG = 3'b000;
  localparam logic [2:0] OP_REG_TO_RAM = 3'b001;
  localparam logic [2:0] OP_ADDI       = 3'b010;
  localparam logic [2:0] OP_MULT       = 3'b011;
  localparam logic [2:0] OP_RAM_TO_OUT = 3'b100;
  localparam logic [2:0] OP_OUT_TO_RAM = 3'b101;

  logic [DATA_W-1:0] ram  [DEPTH];
  logic [DATA_W-1:0] vreg [4][VEC_LEN];

  logic [AW1-1:0]           addr_p0     [VEC_LEN];
  logic                     in_burst_p0 [VEC_LEN];
  logic                     in_range_p0 [VEC_LEN];
  logic                     we_p0       [VEC_LEN];
  logic [DATA_W-1:0]        rd_p0       [VEC_LEN];
  logic [DATA_W-1:0]        wr_p0       [VEC_LEN];
  logic signed [DATA_W:0]   sum_p0      [VEC_LEN];
  logic [2*DATA_W-1:0]      prod_p0     [VEC_LEN];

  function automatic logic signed [DATA_W:0] add_wide(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] ax;
    logic signed [DATA_W:0] bx;
    ax = {a[DATA_W-1], a};
    bx = {b[DATA_W-1], b};
    return ax + bx;
  endfunction

  function automatic logic [2*DATA_W-1:0] mul_wide(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ax;
    logic signed [2*DATA_W-1:0] bx;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [DATA_W-1:0] sign_fill(input logic s);
    return {DATA_W{s}};
  endfunction

  // Stage p0: per-lane burst addressing (10-bit, no wrap), read mux and lane arithmetic
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      addr_p0[i]     = {1'b0, ram_addr} + AW1'(i);
      in_range_p0[i] = addr_p0[i] < AW1'(DEPTH);
      in_burst_p0[i] = CW'(i) <= ram_cnt;
      rd_p0[i]       = in_range_p0[i] ? ram[addr_p0[i][ADDR_W-1:0]] : '0;
      wr_p0[i]       = (op == OP_OUT_TO_RAM) ? ram_input[i] : vreg[reg_sel][i];
      we_p0[i]       = ((op == OP_OUT_TO_RAM) || (op == OP_REG_TO_RAM)) &&
                       in_burst_p0[i] && in_range_p0[i];
      sum_p0[i]      = add_wide(vreg[0][i], vreg[1][i]);
      prod_p0[i]     = mul_wide(vreg[0][i], vreg[1][i]);
    end
  end

  // Stage p1: RAM write commit; out-of-range lanes were already masked in we_p0
`ifdef CPU_RAM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) ram[a] <= '0;
    end else begin
      for (int i = 0; i < VEC_LEN; i++)
        if (we_p0[i]) ram[addr_p0[i][ADDR_W-1:0]] <= wr_p0[i];
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i < VEC_LEN; i++)
      if (we_p0[i]) ram[addr_p0[i][ADDR_W-1:0]] <= wr_p0[i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++)
        for (int i = 0; i < VEC_LEN; i++) vreg[r][i] <= '0;
    end else begin
      case (op)
        OP_RAM_TO_REG: begin
          for (int i = 0; i < VEC_LEN; i++)
            if (in_burst_p0[i]) vreg[reg_sel][i] <= rd_p0[i];
        end
        OP_ADDI: begin
          for (int i = 0; i < VEC_LEN; i++) begin
            vreg[2][i] <= sum_p0[i][DATA_W-1:0];
            vreg[3][i] <= sign_fill(sum_p0[i][DATA_W]);
          end
        end
        OP_MULT: begin
          for (int i = 0; i < VEC_LEN; i++) begin
            vreg[2][i] <= prod_p0[i][DATA_W-1:0];
            vreg[3][i] <= prod_p0[i][2*DATA_W-1:DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  // Output port: words past the burst are zeroed so stale data never leaks out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_LEN; i++) ram_output[i] <= '0;
    end else if (op == OP_RAM_TO_OUT) begin
      for (int i = 0; i < VEC_LEN; i++)
        ram_output[i] <= in_burst_p0[i] ? rd_p0[i] : '0;
    end
  end

endmodule

// File: tb/tb_vec_cpu.sv
// Self-checking bench for vec_cpu: directed steps plus random bursts against a behavioural model.
module tb_vec_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  op = 3'b110;
  logic [8:0]  ram_addr = '0;
  logic [3:0]  ram_cnt = '0;
  logic [1:0]  reg_sel = '0;
  logic [31:0] in_vec  [0:15];
  logic [31:0] out_vec [0:15];

  logic [31:0] m_ram [512];
  logic [31:0] m_reg [4][16];
  logic [31:0] m_out [16];
  logic [31:0] written [16];

  int checks = 0;
  int errors = 0;

  vec_cpu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .ram_addr   (ram_addr),
    .ram_cnt    (ram_cnt),
    .reg_sel    (reg_sel),
    .ram_input  (in_vec),
    .ram_output (out_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_rd(input int a);
    return (a > 511) ? 32'h0 : m_ram[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 16; i++) m_reg[r][i] = '0;
    for (int i = 0; i < 16; i++) m_out[i] = '0;
`ifdef CPU_RAM_CLEAR_EN
    for (int a = 0; a < 512; a++) m_ram[a] = '0;
`endif
  endtask

  task automatic run_op(input logic [2:0] o, input int a, input int c, input int s);
    longint x;
    longint y;
    longint r;
    @(negedge clk);
    op = o; ram_addr = 9'(a); ram_cnt = 4'(c); reg_sel = 2'(s);
    @(posedge clk);
    #1;
    case (o)
      3'd0: for (int i = 0; i <= c; i++) m_reg[s][i] = m_rd(a + i);
      3'd1: for (int i = 0; i <= c; i++) if (a + i < 512) m_ram[a + i] = m_reg[s][i];
      3'd2, 3'd3: begin
        for (int i = 0; i < 16; i++) begin
          x = longint'($signed(m_reg[0][i]));
          y = longint'($signed(m_reg[1][i]));
          if (o == 3'd2) begin
            r = x + y;
            m_reg[2][i] = r[31:0];
            m_reg[3][i] = (r < 0) ? 32'hFFFF_FFFF : 32'h0;
          end else begin
            r = x * y;
            m_reg[2][i] = r[31:0];
            m_reg[3][i] = r[63:32];
          end
        end
      end
      3'd4: for (int i = 0; i < 16; i++) m_out[i] = (i <= c) ? m_rd(a + i) : 32'h0;
      3'd5: for (int i = 0; i <= c; i++) if (a + i < 512) m_ram[a + i] = in_vec[i];
      default: ;
    endcase
    @(negedge clk);
    op = 3'b110;
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] got,
                            input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, idx, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < 16; i++)
      if (!$isunknown(m_out[i])) check_word(tag, i, out_vec[i], m_out[i]);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) in_vec[i] = $urandom;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 16; i++) in_vec[i] = v;
  endtask

  initial begin
    for (int a = 0; a < 512; a++) m_ram[a] = 'x;
    for (int i = 0; i < 16; i++) in_vec[i] = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 16; i++) check_word("reset_out", i, out_vec[i], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents in low RAM to detect aliasing from the top boundary
    fill_rand();
    run_op(3'd5, 0, 3, 0);
    run_op(3'd4, 0, 3, 0);
    check_out("low_init");

    // Round trip at 12
    fill_rand();
    for (int i = 0; i < 16; i++) written[i] = in_vec[i];
    run_op(3'd5, 12, 15, 0);
    run_op(3'd4, 12, 15, 0);
    check_out("round_trip");
    for (int i = 0; i < 16; i++) check_word("round_trip_abs", i, out_vec[i], written[i]);

    // Offset read
    run_op(3'd4, 13, 15, 0);
    check_out("offset_read");
    for (int i = 0; i < 15; i++) check_word("offset_abs", i, out_vec[i], written[i + 1]);

    // Top boundary
    fill_rand();
    for (int i = 0; i < 16; i++) written[i] = in_vec[i];
    run_op(3'd5, 496, 15, 0);
    run_op(3'd4, 496, 15, 0);
    check_out("top_496");
    run_op(3'd4, 500, 15, 0);
    check_out("top_500");
    for (int i = 12; i < 16; i++) check_word("top_zero", i, out_vec[i], 32'h0);
    for (int i = 0; i < 12; i++) check_word("top_abs", i, out_vec[i], written[i + 4]);
    run_op(3'd4, 0, 3, 0);
    check_out("no_alias");

    // Partial burst
    fill_rand();
    run_op(3'd5, 12, 2, 0);
    run_op(3'd4, 12, 15, 0);
    check_out("partial_write");
    run_op(3'd4, 12, 2, 0);
    check_out("partial_read");
    for (int i = 3; i < 16; i++) check_word("partial_zero", i, out_vec[i], 32'h0);

    // addi overflow: 7FFFFFFF + 1
    fill_const(32'h7FFF_FFFF); run_op(3'd5, 200, 15, 0);
    fill_const(32'h0000_0001); run_op(3'd5, 220, 15, 0);
    run_op(3'd0, 200, 15, 0);
    run_op(3'd0, 220, 15, 1);
    run_op(3'd2, $urandom_range(511), $urandom_range(15), $urandom_range(3));
    run_op(3'd1, 240, 15, 2);
    run_op(3'd1, 260, 15, 3);
    run_op(3'd4, 240, 15, 0);
    check_out("addi_r2");
    for (int i = 0; i < 16; i++) check_word("addi_r2_abs", i, out_vec[i], 32'h8000_0000);
    run_op(3'd4, 260, 15, 0);
    for (int i = 0; i < 16; i++) check_word("addi_r3_abs", i, out_vec[i], 32'h0);

    // mult: -2 * 3
    fill_const(32'hFFFF_FFFE); run_op(3'd5, 200, 15, 0);
    fill_const(32'h0000_0003); run_op(3'd5, 220, 15, 0);
    run_op(3'd0, 200, 15, 0);
    run_op(3'd0, 220, 15, 1);
    run_op(3'd3, 0, 0, 0);
    run_op(3'd1, 240, 15, 2);
    run_op(3'd1, 260, 15, 3);
    run_op(3'd4, 240, 15, 0);
    for (int i = 0; i < 16; i++) check_word("mult_r2_abs", i, out_vec[i], 32'hFFFF_FFFA);
    run_op(3'd4, 260, 15, 0);
    for (int i = 0; i < 16; i++) check_word("mult_r3_abs", i, out_vec[i], 32'hFFFF_FFFF);

    // Random lane arithmetic and partial register loads
    for (int k = 0; k < 6; k++) begin
      int base;
      base = 300 + 32 * (k % 3);
      fill_rand(); run_op(3'd5, base, 15, 0);
      fill_rand(); run_op(3'd5, base + 16, 15, 0);
      run_op(3'd0, base, 15, 0);
      run_op(3'd0, base + 16, $urandom_range(15), 1);
      run_op((k % 2 == 0) ? 3'd2 : 3'd3, 0, 0, 0);
      run_op(3'd1, 400, 15, 2);
      run_op(3'd1, 416, $urandom_range(15), 3);
      run_op(3'd4, 400, 15, 0);
      check_out("rand_r2");
      run_op(3'd4, 416, 15, 0);
      check_out("rand_r3");
    end

    // Random burst traffic including the top edge and NOPs
    for (int k = 0; k < 40; k++) begin
      int a;
      int c;
      a = (k % 4 == 0) ? int'($urandom_range(511, 490)) : int'($urandom_range(511));
      c = $urandom_range(15);
      fill_rand();
      case ($urandom_range(4))
        0: run_op(3'd5, a, c, 0);
        1: run_op(3'd0, a, c, $urandom_range(3));
        2: run_op(3'd1, a, c, $urandom_range(3));
        3: run_op(3'($urandom_range(7, 6)), a, c, 0);
        default: run_op(3'd4, a, c, 0);
      endcase
      run_op(3'd4, a, c, 0);
      check_out("rand_burst");
    end

    // Asynchronous reset mid-sequence
    run_op(3'd4, 12, 15, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 16; i++) check_word("midreset_out", i, out_vec[i], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) run_op(3'd1, 100 + 16 * r, 15, r);
    for (int r = 0; r < 4; r++) begin
      run_op(3'd4, 100 + 16 * r, 15, 0);
      for (int i = 0; i < 16; i++) check_word("midreset_reg", i, out_vec[i], 32'h0);
    end
    run_op(3'd4, 0, 3, 0);
    check_out("ram_kept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
